tri_fetch: RTL and testbench
============================

TRI_FETCH -- requirements
Module: tri_fetch

Interface
REQ-001 The block SHALL use one clock and a synchronous active-high reset: clock, reset.
REQ-002 The ports SHALL be:
  clock  in  1  rising-edge clock
  reset  in  1  synchronous, active-high
  start  in  1  pulse; begin a scene (matrix, then triangles)
  word_in  in  32  stream word, Q16.16 fixed point or packed rgb
  word_valid  in  1  word_in valid
  word_last  in  1  final word of scene, qualified by word_valid
  word_ready  out  1  block accepts word_in this cycle
  stall_in  in  1  downstream vertex stage cannot take the triangle
  mat  out  512  4x4 transform; word k of matrix at mat[511-32k -: 32]
  v_out  out  32 x 15  triangle: x1 y1 z1 rgb1 x2 y2 z2 rgb2 x3 y3 z3 rgb3 nx ny nz
  out_data_valid  out  1  v_out holds a triangle not yet accepted
  done_out  out  1  one-cycle pulse, scene fully delivered
  busy  out  1  state != IDLE
  err  out  1  sticky framing error
  tri_count  out  16  triangles delivered this scene

Function
REQ-003 A stream word SHALL transfer when word_valid && word_ready at a rising clock edge.
REQ-004 A triangle SHALL transfer downstream when out_data_valid && !stall_in at a rising clock edge.
REQ-005 The states SHALL be IDLE, MAT, TRI, HOLD, DRAIN, FIN.
REQ-006 IDLE: word_ready=0; start -> MAT, word_idx=0, tri_count=0, err cleared; start in any other state SHALL be ignored.
REQ-007 MAT: word_ready=1; accepted word k (0..15) SHALL write mat slot k; after word 15 -> TRI, word_idx=0.
REQ-008 mat SHALL change only in MAT and SHALL otherwise hold its value.
REQ-009 TRI: word_ready=1; accepted word i (0..14) SHALL go into assembly slot i; word_idx increments and wraps to 0 after 14.
REQ-010 On accepting word 14, when the output slot is empty or being accepted that same edge, the full triangle (slots 0..13 plus current word) SHALL load v_out with out_data_valid=1 from the next cycle; the state stays TRI, or goes to DRAIN if word_last.
REQ-011 On accepting word 14 with the output slot occupied and not being accepted, the state SHALL go to HOLD; HOLD has word_ready=0 and loads v_out on the first edge where the slot is accepted, then goes to TRI, or to DRAIN if the held triangle was marked last.
REQ-012 Latency: out_data_valid SHALL rise one cycle after word 14 is accepted when no backpressure exists; sustained throughput SHALL be one triangle per 15 cycles.
REQ-013 v_out and out_data_valid SHALL hold stable while out_data_valid && stall_in.
REQ-014 out_data_valid SHALL clear on acceptance unless a new triangle loads on the same edge.
REQ-015 tri_count SHALL increment by 1 on each downstream acceptance and saturate at 16'hFFFF.
REQ-016 DRAIN: word_ready=0; on acceptance of the final triangle -> FIN.
REQ-017 FIN SHALL assert done_out for exactly one cycle, then go to IDLE.
REQ-018 word_last accepted in MAT, or in TRI with word_idx != 14, SHALL set err, discard the partial triangle, and go to DRAIN if out_data_valid, else FIN.
REQ-019 A word_last with word_valid low SHALL be ignored.
REQ-020 busy SHALL be 1 in every state except IDLE.

Reset
REQ-021 In the cycle after reset is sampled high, the block SHALL be in IDLE with word_ready=0, out_data_valid=0, done_out=0, err=0, tri_count=0, mat=0, v_out all 0, word_idx=0.
REQ-022 Reset SHALL override all other inputs, including mid-scene; a pending triangle SHALL be dropped with no done_out.

Verification
REQ-023 Matrix load: start, then words 0x00010000 x16 with no stall -> mat every slot 0x00010000, state TRI, busy=1.
REQ-024 Single triangle: after the matrix, words 1..15, last on word 15, stall_in=0 -> v_out[0]=1 and v_out[14]=15; out_data_valid high 1 cycle after the final accept, then low; done_out pulses 2 cycles after the final accept; tri_count=1.
REQ-025 Backpressure: two back-to-back triangles with stall_in=1 held for 20 cycles after the first completes -> HOLD entered, word_ready=0, v_out unchanged for 20 cycles; after stall_in drops, the second triangle appears the next cycle; tri_count=2 and done_out once.
REQ-026 Framing error: word_last on triangle word 6 -> err=1, partial triangle never appears, done_out pulses, tri_count unchanged; the next start clears err.
REQ-027 Reset mid-HOLD with stall_in=1 -> next cycle out_data_valid=0, word_ready=0, state IDLE, no done_out; start while busy is ignored (word_idx unaffected).

Source files
------------

// File: rtl/tri_fetch.sv
// Scene fetch front end: loads a 4x4 transform, then assembles 15-word triangles
// from the input stream and hands them downstream through a single output slot.
//
// state | meaning
// IDLE  | waiting for start
// MAT   | accepting the 16 matrix words
// TRI   | accepting triangle words into the assembly buffer
// HOLD  | full triangle assembled, output slot still occupied
// DRAIN | stream finished, waiting for the last triangle to be taken
// FIN   | one-cycle done_out pulse
module tri_fetch (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       word_in,
  input  logic              word_valid,
  input  logic              word_last,
  output logic              word_ready,
  input  logic              stall_in,
  output logic [511:0]      mat,
  output logic [14:0][31:0] v_out,
  output logic              out_data_valid,
  output logic              done_out,
  output logic              busy,
  output logic              err,
  output logic [15:0]       tri_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_MAT, S_TRI, S_HOLD, S_DRAIN, S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        word_idx;
  logic [15:0][31:0] mat_q;
  logic [14:0][31:0] asm_q;
  logic              held_last;

  logic take, accept_out;
  logic start_scene, set_err, load_direct, load_held, go_hold;

  assign take       = word_valid && word_ready;
  assign accept_out = out_data_valid && !stall_in;
  assign busy       = (state_q != S_IDLE);
  assign mat        = mat_q;

  always_comb begin
    state_d     = state_q;
    word_ready  = 1'b0;
    done_out    = 1'b0;
    start_scene = 1'b0;
    set_err     = 1'b0;
    load_direct = 1'b0;
    load_held   = 1'b0;
    go_hold     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_scene = 1'b1;
          state_d     = S_MAT;
        end
      end
      S_MAT: begin
        word_ready = 1'b1;
        if (word_valid) begin
          if (word_last) begin
            set_err = 1'b1;
            state_d = (out_data_valid && !accept_out) ? S_DRAIN : S_FIN;
          end else if (word_idx == 4'd15) begin
            state_d = S_TRI;
          end
        end
      end
      S_TRI: begin
        word_ready = 1'b1;
        if (word_valid) begin
          if (word_idx == 4'd14) begin
            if (!out_data_valid || accept_out) begin
              load_direct = 1'b1;
              state_d     = word_last ? S_DRAIN : S_TRI;
            end else begin
              go_hold = 1'b1;
              state_d = S_HOLD;
            end
          end else if (word_last) begin
            // Short triangle: drop it, but still deliver whatever is already in the slot.
            set_err = 1'b1;
            state_d = (out_data_valid && !accept_out) ? S_DRAIN : S_FIN;
          end
        end
      end
      S_HOLD: begin
        if (accept_out) begin
          load_held = 1'b1;
          state_d   = held_last ? S_DRAIN : S_TRI;
        end
      end
      S_DRAIN: begin
        if (!out_data_valid || accept_out) state_d = S_FIN;
      end
      S_FIN: begin
        done_out = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      word_idx       <= 4'd0;
      mat_q          <= '0;
      asm_q          <= '0;
      held_last      <= 1'b0;
      v_out          <= '0;
      out_data_valid <= 1'b0;
      err            <= 1'b0;
      tri_count      <= 16'd0;
    end else begin
      state_q <= state_d;

      if (start_scene) begin
        word_idx  <= 4'd0;
        tri_count <= 16'd0;
        err       <= 1'b0;
      end

      if (set_err) err <= 1'b1;

      if (take && state_q == S_MAT) begin
        mat_q[4'd15 - word_idx] <= word_in;
        word_idx <= (word_idx == 4'd15 || word_last) ? 4'd0 : word_idx + 4'd1;
      end

      if (take && state_q == S_TRI) begin
        if (word_idx != 4'd15) asm_q[word_idx] <= word_in;
        word_idx <= (word_idx == 4'd14 || word_last) ? 4'd0 : word_idx + 4'd1;
      end

      if (go_hold) held_last <= word_last;

      if (load_direct) begin
        v_out          <= {word_in, asm_q[13:0]};
        out_data_valid <= 1'b1;
      end else if (load_held) begin
        v_out          <= asm_q;
        out_data_valid <= 1'b1;
      end else if (accept_out) begin
        out_data_valid <= 1'b0;
      end

      if (accept_out && tri_count != 16'hFFFF) tri_count <= tri_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_tri_fetch.sv
// Directed bench for tri_fetch: expected triangles go into a scoreboard queue,
// a negedge monitor pops and compares each one as it is accepted downstream.
module tb_tri_fetch;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [31:0]       word_in = '0;
  logic              word_valid = 1'b0;
  logic              word_last = 1'b0;
  logic              word_ready;
  logic              stall_in = 1'b0;
  logic [511:0]      mat;
  logic [14:0][31:0] v_out;
  logic              out_data_valid;
  logic              done_out;
  logic              busy;
  logic              err;
  logic [15:0]       tri_count;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic [479:0] exp_q[$];

  tri_fetch dut (
    .clock(clock), .reset(reset), .start(start),
    .word_in(word_in), .word_valid(word_valid), .word_last(word_last),
    .word_ready(word_ready), .stall_in(stall_in), .mat(mat),
    .v_out(v_out), .out_data_valid(out_data_valid), .done_out(done_out),
    .busy(busy), .err(err), .tri_count(tri_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [479:0] make_tri(input logic [31:0] base);
    logic [479:0] t;
    for (int i = 0; i < 15; i++) t[32*i +: 32] = base + 32'(i) + 32'd1;
    return t;
  endfunction

  // Monitor: triangle acceptance, stall stability and done pulses.
  logic         prev_stalled = 1'b0;
  logic [479:0] prev_v = '0;
  always @(negedge clock) begin
    if (prev_stalled && !reset) begin
      check("stall_hold_valid", {511'b0, out_data_valid}, 512'd1);
      check("stall_hold_vout", {32'b0, v_out}, {32'b0, prev_v});
    end
    prev_stalled <= out_data_valid && stall_in && !reset;
    prev_v       <= v_out;
    if (!reset && done_out) done_cnt++;
    if (!reset && out_data_valid && !stall_in) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_tri actual=%0h expected=none", v_out);
      end else begin
        check("tri_data", {32'b0, v_out}, {32'b0, exp_q.pop_front()});
      end
    end
  end

  task automatic send_word(input logic [31:0] w, input logic last);
    int n = 0;
    word_in = w; word_valid = 1'b1; word_last = last;
    while (!word_ready && n < 200) begin @(posedge clock); #1; n++; end
    if (!word_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout actual=word_ready_low expected=word_ready_high");
    end
    @(posedge clock); #1;
    word_valid = 1'b0; word_last = 1'b0;
  endtask

  task automatic send_tri(input logic [31:0] base, input logic last);
    for (int i = 0; i < 15; i++) send_word(base + 32'(i) + 32'd1, last && (i == 14));
  endtask

  task automatic pulse_start();
    start = 1'b1; @(posedge clock); #1; start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [511:0] mexp;
    logic [479:0] ta, tb;

    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_word_ready", {511'b0, word_ready}, 512'd0);
    check("rst_valid", {511'b0, out_data_valid}, 512'd0);
    check("rst_done", {511'b0, done_out}, 512'd0);
    check("rst_err", {511'b0, err}, 512'd0);
    check("rst_busy", {511'b0, busy}, 512'd0);
    check("rst_count", {496'b0, tri_count}, 512'd0);
    check("rst_mat", mat, 512'd0);
    check("rst_vout", {32'b0, v_out}, 512'd0);

    // Matrix load of identity-ish words, then a single last triangle.
    @(posedge clock); #1;
    pulse_start();
    @(negedge clock);
    check("mat_busy", {511'b0, busy}, 512'd1);
    check("mat_ready", {511'b0, word_ready}, 512'd1);
    for (int k = 0; k < 16; k++) send_word(32'h0001_0000, 1'b0);
    @(negedge clock);
    check("mat_ones", mat, {16{32'h0001_0000}});
    check("tri_busy", {511'b0, busy}, 512'd1);
    check("tri_ready", {511'b0, word_ready}, 512'd1);

    exp_q.push_back(make_tri(32'd0));
    send_tri(32'd0, 1'b1);
    @(negedge clock);
    check("single_valid", {511'b0, out_data_valid}, 512'd1);
    check("single_v0", {480'b0, v_out[0]}, 512'd1);
    check("single_v14", {480'b0, v_out[14]}, 512'd15);
    check("drain_ready", {511'b0, word_ready}, 512'd0);
    check("single_nodone", {511'b0, done_out}, 512'd0);
    @(negedge clock);
    check("single_valid_low", {511'b0, out_data_valid}, 512'd0);
    check("single_done", {511'b0, done_out}, 512'd1);
    check("single_count", {496'b0, tri_count}, 512'd1);
    @(negedge clock);
    check("single_idle", {511'b0, busy}, 512'd0);
    check("single_done_once", 512'(done_cnt), 512'd1);

    // Ordered matrix, then two triangles with backpressure; start mid-triangle is ignored.
    @(posedge clock); #1;
    pulse_start();
    mexp = '0;
    for (int k = 0; k < 16; k++) begin
      send_word(32'h100 + 32'(k), 1'b0);
      mexp[511 - 32*k -: 32] = 32'h100 + 32'(k);
    end
    @(negedge clock);
    check("mat_order", mat, mexp);
    ta = make_tri(32'hA0);
    tb = make_tri(32'hB0);
    exp_q.push_back(ta);
    exp_q.push_back(tb);
    for (int i = 0; i < 7; i++) send_word(32'hA0 + 32'(i) + 32'd1, 1'b0);
    pulse_start();
    for (int i = 7; i < 15; i++) send_word(32'hA0 + 32'(i) + 32'd1, 1'b0);
    stall_in = 1'b1;
    fork
      send_tri(32'hB0, 1'b1);
      begin
        repeat (17) @(posedge clock);
        @(negedge clock);
        check("hold_ready", {511'b0, word_ready}, 512'd0);
        check("hold_valid", {511'b0, out_data_valid}, 512'd1);
        check("hold_vout_a", {32'b0, v_out}, {32'b0, ta});
        repeat (3) @(posedge clock);
        #1 stall_in = 1'b0;
      end
    join
    @(posedge clock);
    @(negedge clock);
    check("second_appears", {32'b0, v_out}, {32'b0, tb});
    check("second_valid", {511'b0, out_data_valid}, 512'd1);
    @(negedge clock);
    check("bp_done", {511'b0, done_out}, 512'd1);
    check("bp_count", {496'b0, tri_count}, 512'd2);
    @(negedge clock);
    check("bp_done_once", 512'(done_cnt), 512'd2);

    // Framing error on the sixth triangle word.
    @(posedge clock); #1;
    pulse_start();
    for (int k = 0; k < 16; k++) send_word(32'h200 + 32'(k), 1'b0);
    for (int i = 0; i < 6; i++) send_word(32'hE0 + 32'(i), i == 5);
    @(negedge clock);
    check("ferr_err", {511'b0, err}, 512'd1);
    check("ferr_done", {511'b0, done_out}, 512'd1);
    check("ferr_valid", {511'b0, out_data_valid}, 512'd0);
    check("ferr_count", {496'b0, tri_count}, 512'd0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("ferr_sticky", {511'b0, err}, 512'd1);
    pulse_start();
    @(negedge clock);
    check("ferr_cleared", {511'b0, err}, 512'd0);

    // Reset while holding a second triangle under stall.
    for (int k = 0; k < 16; k++) send_word(32'h300 + 32'(k), 1'b0);
    stall_in = 1'b1;
    send_tri(32'hC0, 1'b0);
    send_tri(32'hD0, 1'b0);
    @(negedge clock);
    check("hold2_ready", {511'b0, word_ready}, 512'd0);
    check("hold2_valid", {511'b0, out_data_valid}, 512'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("mrst_valid", {511'b0, out_data_valid}, 512'd0);
    check("mrst_ready", {511'b0, word_ready}, 512'd0);
    check("mrst_busy", {511'b0, busy}, 512'd0);
    check("mrst_done", {511'b0, done_out}, 512'd0);
    check("mrst_vout", {32'b0, v_out}, 512'd0);
    stall_in = 1'b0;
    repeat (5) @(negedge clock);
    check("total_done", 512'(done_cnt), 512'd3);
    check("queue_empty", 512'(exp_q.size()), 512'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
